// File: rtl/targ_fb_queue.sv
// Target-predictor feedback queue: gathers resolved indirect jumps from
// several ports and feeds them to the predictor one entry per cycle.
module targ_fb_queue #(
  parameter int fb_ports = 2,
  parameter int depth    = 8,
  parameter int pc_width = 32
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               flush,
  input  logic [fb_ports-1:0]                in_valid,
  input  logic [fb_ports-1:0][pc_width-1:0]  in_base_pc,
  input  logic [fb_ports-1:0][pc_width-1:0]  in_targ_pc,
  input  logic                               out_ready,
  output logic                               out_valid,
  output logic [pc_width-1:0]                out_base_pc,
  output logic [pc_width-1:0]                out_targ_pc,
  output logic                               full,
  output logic [$clog2(depth+1)-1:0]         count,
  output logic [15:0]                        drop_cnt
);

  localparam int AW = $clog2(depth);
  localparam int CW = $clog2(depth+1);
  localparam int EW = 2*pc_width;

  logic [EW-1:0]       mem_q [depth];
  logic [AW-1:0]       rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]       wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]       count_q, count_d;
  logic                last_vld_q, last_vld_d;
  logic [pc_width-1:0] last_base_q, last_base_d;
  logic [pc_width-1:0] last_targ_q, last_targ_d;
  logic [15:0]         drop_q, drop_d;

  logic                pop;
  logic [fb_ports-1:0] we;
  logic [AW-1:0]       waddr [fb_ports];
  logic [CW:0]         space;
  logic [CW:0]         acc;
  logic [2:0]          drops;
  logic [16:0]         drop_sum;
  logic                dup;

  assign out_valid   = (count_q != '0);
  assign out_base_pc = out_valid ? mem_q[rd_ptr_q][EW-1:pc_width] : '0;
  assign out_targ_pc = out_valid ? mem_q[rd_ptr_q][pc_width-1:0]  : '0;
  assign full        = (count_q == CW'(depth));
  assign count       = count_q;
  assign drop_cnt    = drop_q;
  assign pop         = out_valid && out_ready && !flush;

  // Ports are walked in index order carrying a running last pair,
  // write pointer and free-space count.
  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    last_vld_d  = last_vld_q;
    last_base_d = last_base_q;
    last_targ_d = last_targ_q;
    space = (CW+1)'(depth) - {1'b0, count_q} + (CW+1)'(pop);
    acc   = '0;
    drops = '0;
    dup   = 1'b0;
    we    = '0;
    for (int i = 0; i < fb_ports; i++) begin
      waddr[i] = wr_ptr_d;
      if (in_valid[i] && !flush) begin
        dup = last_vld_d && in_base_pc[i] == last_base_d
                         && in_targ_pc[i] == last_targ_d;
        if (!dup) begin
          if (space != '0) begin
            we[i]       = 1'b1;
            wr_ptr_d    = wr_ptr_d + AW'(1);
            acc         = acc + (CW+1)'(1);
            space       = space - (CW+1)'(1);
            last_vld_d  = 1'b1;
            last_base_d = in_base_pc[i];
            last_targ_d = in_targ_pc[i];
          end else begin
            drops = drops + 3'd1;
          end
        end
      end
    end
    rd_ptr_d = rd_ptr_q + AW'(pop);
    count_d  = CW'({1'b0, count_q} + acc - (CW+1)'(pop));
    drop_sum = {1'b0, drop_q} + 17'(drops);
    drop_d   = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
    if (flush) begin
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      count_d    = '0;
      last_vld_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      count_q     <= '0;
      last_vld_q  <= 1'b0;
      last_base_q <= '0;
      last_targ_q <= '0;
      drop_q      <= '0;
    end else begin
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      count_q     <= count_d;
      last_vld_q  <= last_vld_d;
      last_base_q <= last_base_d;
      last_targ_q <= last_targ_d;
      drop_q      <= drop_d;
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < fb_ports; i++) begin
      if (we[i]) mem_q[waddr[i]] <= {in_base_pc[i], in_targ_pc[i]};
    end
  end

endmodule

// File: tb/tb_targ_fb_queue.sv
// Directed bench for targ_fb_queue (fb_ports=2, depth=8, pc_width=32).
// Expected values are hand-computed constants.
module tb_targ_fb_queue;

  logic             clk = 1'b0;
  logic             rst;
  logic             flush;
  logic [1:0]       in_valid;
  logic [1:0][31:0] in_base_pc;
  logic [1:0][31:0] in_targ_pc;
  logic             out_ready;
  logic             out_valid;
  logic [31:0]      out_base_pc;
  logic [31:0]      out_targ_pc;
  logic             full;
  logic [3:0]       count;
  logic [15:0]      drop_cnt;

  int checks = 0;
  int failures = 0;

  targ_fb_queue #(.fb_ports(2), .depth(8), .pc_width(32)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_base_pc(in_base_pc),
    .in_targ_pc(in_targ_pc), .out_ready(out_ready),
    .out_valid(out_valid), .out_base_pc(out_base_pc),
    .out_targ_pc(out_targ_pc), .full(full),
    .count(count), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drv(input logic [1:0] v,
                     input logic [31:0] b0, input logic [31:0] t0,
                     input logic [31:0] b1, input logic [31:0] t1);
    in_valid      = v;
    in_base_pc[0] = b0;
    in_targ_pc[0] = t0;
    in_base_pc[1] = b1;
    in_targ_pc[1] = t1;
  endtask

  task automatic idle();
    drv(2'b00, 0, 0, 0, 0);
  endtask

  initial begin
    rst = 1'b1;
    flush = 1'b0;
    out_ready = 1'b0;
    idle();
    #12;
    check("rst_valid", 32'(out_valid), 0);
    check("rst_base", out_base_pc, 0);
    check("rst_targ", out_targ_pc, 0);
    check("rst_count", 32'(count), 0);
    check("rst_drop", 32'(drop_cnt), 0);
    check("rst_full", 32'(full), 0);
    rst = 1'b0;
    step();

    // two ports in one cycle, then drain in order
    drv(2'b11, 32'h100, 32'h200, 32'h104, 32'h300);
    step();
    idle();
    check("c1_base", out_base_pc, 32'h100);
    check("c1_targ", out_targ_pc, 32'h200);
    check("c1_count", 32'(count), 2);
    out_ready = 1'b1;
    step();
    check("c2_base", out_base_pc, 32'h104);
    check("c2_targ", out_targ_pc, 32'h300);
    step();
    check("c3_valid", 32'(out_valid), 0);
    out_ready = 1'b0;

    // duplicate suppression within and across cycles
    drv(2'b11, 32'h100, 32'h200, 32'h100, 32'h200);
    step();
    drv(2'b01, 32'h100, 32'h200, 0, 0);
    step();
    idle();
    check("dup_count", 32'(count), 1);
    check("dup_drop", 32'(drop_cnt), 0);
    drv(2'b01, 32'h100, 32'h204, 0, 0);
    step();
    idle();
    check("dup_new_count", 32'(count), 2);
    out_ready = 1'b1;
    step();
    step();
    check("dup_drain", 32'(count), 0);
    out_ready = 1'b0;

    // fill to 7, then overflow
    for (int k = 0; k < 6; k += 2) begin
      drv(2'b11, 32'h1000 + 4*k, 32'h2000 + k,
                 32'h1000 + 4*(k+1), 32'h2000 + k + 1);
      step();
    end
    drv(2'b01, 32'h1018, 32'h2006, 0, 0);
    step();
    idle();
    check("fill7_count", 32'(count), 7);
    drv(2'b11, 32'h101c, 32'h2007, 32'h1020, 32'h2008);
    step();
    idle();
    check("ovf_full", 32'(full), 1);
    check("ovf_count", 32'(count), 8);
    check("ovf_drop", 32'(drop_cnt), 1);
    out_ready = 1'b1;
    drv(2'b11, 32'h1024, 32'h2009, 32'h1028, 32'h200a);
    step();
    idle();
    out_ready = 1'b0;
    check("ovfpop_count", 32'(count), 8);
    check("ovfpop_drop", 32'(drop_cnt), 2);
    check("ovfpop_head", out_base_pc, 32'h1004);
    out_ready = 1'b1;
    repeat (4) step();
    out_ready = 1'b0;
    check("drain4_count", 32'(count), 4);
    check("drain4_head", out_base_pc, 32'h1014);

    // flush beats input and pop; last pair is forgotten
    flush = 1'b1;
    out_ready = 1'b1;
    drv(2'b01, 32'h102c, 32'h200b, 0, 0);
    step();
    flush = 1'b0;
    out_ready = 1'b0;
    idle();
    check("flush_count", 32'(count), 0);
    check("flush_valid", 32'(out_valid), 0);
    check("flush_drop", 32'(drop_cnt), 2);
    drv(2'b01, 32'h1024, 32'h2009, 0, 0);
    step();
    idle();
    check("reenq_count", 32'(count), 1);
    check("reenq_base", out_base_pc, 32'h1024);
    check("reenq_targ", out_targ_pc, 32'h2009);
    out_ready = 1'b1;
    step();
    check("reenq_drain", 32'(count), 0);

    // continuous push/pop across pointer wrap
    for (int k = 0; k < 20; k++) begin
      drv(2'b01, 32'h5000 + 4*k, 32'h6000 + k, 0, 0);
      step();
      check("strm_base", out_base_pc, 32'h5000 + 4*k);
      check("strm_targ", out_targ_pc, 32'h6000 + k);
      check("strm_count", 32'(count), 1);
    end
    idle();
    step();
    check("strm_empty", 32'(out_valid), 0);
    out_ready = 1'b0;

    // async reset with 5 queued
    drv(2'b11, 32'h7000, 32'h8000, 32'h7004, 32'h8004);
    step();
    drv(2'b11, 32'h7008, 32'h8008, 32'h700c, 32'h800c);
    step();
    drv(2'b01, 32'h7010, 32'h8010, 0, 0);
    step();
    idle();
    check("pre_rst_count", 32'(count), 5);
    #1;
    rst = 1'b1;
    #1;
    check("arst_valid", 32'(out_valid), 0);
    check("arst_base", out_base_pc, 0);
    check("arst_targ", out_targ_pc, 0);
    check("arst_count", 32'(count), 0);
    check("arst_drop", 32'(drop_cnt), 0);
    check("arst_full", 32'(full), 0);
    rst = 1'b0;
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/targ_fb_queue.md
Name: targ_fb_queue

Overview:
- Collects resolved indirect-jump outcomes from several execute/commit ports and serialises them into the single-entry-per-cycle feedback input of the target predictor (valid, base_pc, targ_pc).
- Circular FIFO with multi-enqueue per cycle, one dequeue per cycle, back-to-back duplicate suppression and a saturating overflow-drop counter.
- Feedback is a training hint, so overflow drops entries instead of back-pressuring execute.

Parameters:
fb_ports, 2, number of resolve ports enqueuing per cycle (1..4)
depth, 8, FIFO entries (power of two, >= fb_ports)
pc_width, 32, width of base_pc and targ_pc

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
flush  in  1  discard all queued entries
in_valid  in  [fb_ports]  resolve port i carries an outcome
in_base_pc  in  [fb_ports][pc_width]  PC of resolved jump, port i
in_targ_pc  in  [fb_ports][pc_width]  resolved target, port i
out_ready  in  1  predictor accepts feedback this cycle (its en)
out_valid  out  1  head entry valid
out_base_pc  out  pc_width  head base_pc
out_targ_pc  out  pc_width  head targ_pc
full  out  1  count == depth
count  out  clog2(depth+1)  occupancy
drop_cnt  out  16  saturating count of overflow-dropped entries

Behaviour:
- State: mem[depth] of {base_pc, targ_pc}; rd_ptr and wr_ptr of clog2(depth) bits with natural wrap; count; last_vld/last_base/last_targ (most recently enqueued pair); drop_cnt.
- Reset (async): rd_ptr=wr_ptr=count=0, last_vld=0, drop_cnt=0. Outputs after reset: out_valid=0, out_base_pc=0, out_targ_pc=0, full=0, count=0, drop_cnt=0. mem contents need no reset.
- Outputs are combinational from registered state. out_valid = (count!=0). out_base_pc/out_targ_pc = mem[rd_ptr] when out_valid, else 0.
- pop = out_valid && out_ready && !flush. A pop advances rd_ptr by 1.
- Flush has priority over everything except reset. It sets rd_ptr=wr_ptr=count=0 and last_vld=0, and ignores all in_valid and the pop in that cycle. drop_cnt is retained.
- Enqueue processes ports in ascending index within a cycle:
  - space = depth - count + pop. A pop frees its slot the same cycle, so full + pop + 1 input is accepted.
  - Port i is a duplicate if its {base,targ} equals the running last pair (last_vld, or the pair already accepted from a lower port this cycle). Duplicates are discarded silently: no write, no drop count.
  - A non-duplicate with space remaining is written at the running wr_ptr. wr_ptr, count and the last pair update, and space decrements.
  - A non-duplicate with no space is dropped and drop_cnt increments. drop_cnt saturates at 0xFFFF, and can increment by up to fb_ports in one cycle (clamped).
- Dropped entries do not update the last pair.
- count_next = count + accepted - pop. It never exceeds depth and never underflows.
- Latency: an entry accepted in cycle N is visible on out_* in cycle N+1 at the earliest. An empty queue is never bypassed.
- Ordering: strictly FIFO. Port order is the enqueue order within a cycle.
- rd_ptr/wr_ptr wrap from depth-1 to 0 with no bubble.

Test Plan:
- Reset then idle: out_valid=0, out_*=0, count=0, drop_cnt=0. Assert rst mid-queue with count=5 -> same values immediately, before any clock edge.
- Cycle 0: port0=(0x100,0x200), port1=(0x104,0x300), out_ready=0. Cycle 1 -> out=(0x100,0x200), count=2. out_ready=1 -> cycle 2 out=(0x104,0x300), cycle 3 out_valid=0.
- Both ports (0x100,0x200) in one cycle, then the same pair on port0 next cycle -> count=1, drop_cnt=0. Then (0x100,0x204) -> count=2.
- depth=8: fill to 7, then offer 2 distinct entries with out_ready=0 -> port0 accepted, port1 dropped; full=1, drop_cnt=1. Repeat with out_ready=1 and count=8 -> one accepted, one dropped, count stays 8.
- Push and pop 20 distinct entries continuously (ptr wrap) -> outputs emerge in order with no bubble after the first; count stays 1.
- flush together with a valid input and out_ready=1 at count=4 -> next cycle count=0, out_valid=0, drop_cnt unchanged. Re-enqueuing the last pre-flush pair is accepted (last_vld was cleared).
